// File: rtl/fc_ram_loader.sv
// fc_ram_loader: writes a valid/ready word stream into the FC memory at consecutive addresses from a base.
// Define FC_LOAD_CHECKSUM_EN to add a running modulo-2^DATA_W checksum output of accepted words.
module fc_ram_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
`ifdef FC_LOAD_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W+1:0] MEM_WORDS = {2'b01, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LAST_WORD = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W+1:0] range_end;
  logic              range_bad;
  logic              xfer;

  // Two extra bits so base+length can never overflow the comparison.
  assign range_end = {2'b00, base_addr} + {1'b0, length};
  assign range_bad = (range_end > MEM_WORDS);
  assign s_ready   = (state == LOAD);
  assign xfer      = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_we      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (range_bad) begin
              err <= 1'b1;
            end else begin
              err       <= 1'b0;
              cur_addr  <= base_addr;
              remaining <= length;
              busy      <= 1'b1;
              if (length == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= LOAD;
              end
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            mem_we      <= 1'b1;
            mem_address <= cur_addr;
            mem_data    <= s_data;
            cur_addr    <= cur_addr + 1'b1;
            remaining   <= remaining - 1'b1;
            // The final write and the done pulse land in the same cycle.
            if (remaining == LAST_WORD) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FC_LOAD_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (state == IDLE && start && !range_bad) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + s_data;
    end
  end
`endif

endmodule
